serial_prio_enc: RTL and testbench

//   Parametrised sequential successor to the fixed 16-to-4 encoder.
//   - Captures an N-bit request vector over a valid/ready handshake.
//   - Emits the index of every set bit, one per output beat, highest index first.
//   - Flags the last beat, and the "no bit set" case.
//   - Feeds index-driven consumers (decoder / event loggers) that need all set bits,
//     not just the top one.

---
 rtl/serial_prio_enc_pkg.sv | 20 ++
 rtl/serial_prio_enc_prio_enc.sv | 29 ++
 rtl/serial_prio_enc.sv | 95 +++++++++
 tb/tb_serial_prio_enc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_prio_enc_pkg.sv
// Shared types and helpers for the serial priority encoder and its combinational core.
package enc_pkg;

  localparam int MAX_N = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } enc_state_t;

  function automatic int idx_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  // True when at most one bit is set: clearing the lowest set bit leaves zero.
  function automatic logic popcnt_le1(input logic [MAX_N-1:0] vec);
    return (vec & (vec - {{(MAX_N-1){1'b0}}, 1'b1})) == '0;
  endfunction

endpackage

// File: rtl/serial_prio_enc_prio_enc.sv
// Combinational priority encoder: index of the highest set bit, or the lowest
// when SERIAL_PRIO_ENC_LSB_FIRST_EN is defined; index 0 for an all-zero vector.
module prio_enc
  import enc_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    // NOTE: defaults first so every path assigns idx and no latch is inferred.
    idx = '0;
    any = |vec;
`ifdef SERIAL_PRIO_ENC_LSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
`else
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
`endif
  end

endmodule

// File: rtl/serial_prio_enc.sv
// Serial priority encoder: captures a request vector and emits one beat per set bit.
// Beat order is highest index first unless SERIAL_PRIO_ENC_LSB_FIRST_EN is defined.
module serial_prio_enc
  import enc_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_any,
  output logic         out_last
);

  enc_state_t       state, state_nxt;
  logic [N-1:0]     mask;
  logic             any_r;
  logic [N-1:0]     enc_vec;
  logic [W-1:0]     enc_idx;
  logic             enc_any;
  logic [MAX_N-1:0] mask_ext;
  logic             last;

  // While idle the encoder looks at the incoming request so its any flag can be captured.
  assign enc_vec = (state == IDLE) ? req : mask;

  prio_enc #(.N(N)) u_prio_enc (
    .vec (enc_vec),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    mask_ext         = '0;
    mask_ext[N-1:0]  = mask;
  end

  assign last = popcnt_le1(mask_ext);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = BUSY;
      BUSY:    if (out_ready && last) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask  <= '0;
      any_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mask  <= req;
          any_r <= enc_any;
        end
        BUSY: if (out_ready) mask <= mask & ~({{(N-1){1'b0}}, 1'b1} << enc_idx);
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_any   = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        out_valid = 1'b1;
        out_idx   = enc_idx;
        out_any   = any_r;
        out_last  = last;
      end
      default: in_ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_prio_enc.sv
// Self-checking bench for serial_prio_enc: reference beat queue per captured vector,
// per-cycle compare process, directed scenarios and a randomized soak.
module tb_serial_prio_enc;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int N5 = 5;
  localparam int W5 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_any, out_last;
  logic [N-1:0]  req;
  logic [W-1:0]  out_idx;

  logic          v5_in_valid, v5_in_ready, v5_out_valid, v5_out_ready, v5_out_any, v5_out_last;
  logic [N5-1:0] v5_req;
  logic [W5-1:0] v5_out_idx;

  int checks = 0;
  int errors = 0;

  int  exp_q[$];
  bit  exp_any;
  int  obs_q[$];

  always #5 clk = ~clk;

  serial_prio_enc #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .req(req),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_any(out_any), .out_last(out_last)
  );

  serial_prio_enc #(.N(N5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5_in_valid), .in_ready(v5_in_ready), .req(v5_req),
    .out_valid(v5_out_valid), .out_ready(v5_out_ready), .out_idx(v5_out_idx),
    .out_any(v5_out_any), .out_last(v5_out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected beats: the set indices in emission order; a zero vector yields one beat of 0.
  function automatic void load(input logic [N-1:0] v);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
`ifdef SERIAL_PRIO_ENC_LSB_FIRST_EN
      if (v[i]) exp_q.push_back(i);
`else
      if (v[i]) exp_q.push_front(i);
`endif
    end
    exp_any = (exp_q.size() != 0);
    if (exp_q.size() == 0) exp_q.push_back(0);
  endfunction

  // Compare process: inputs change just after posedge, so at negedge they hold for the next edge.
  initial begin
    bit busy;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_any",   out_any,   0);
        check("rst_out_last",  out_last,  0);
      end else begin
        busy = (exp_q.size() != 0);
        check("in_ready",  in_ready,  !busy);
        check("out_valid", out_valid, busy);
        if (busy) begin
          check("out_idx",  out_idx,  exp_q[0]);
          check("out_any",  out_any,  exp_any);
          check("out_last", out_last, exp_q.size() == 1);
          if (out_ready) begin
            obs_q.push_back(int'(out_idx));
            void'(exp_q.pop_front());
          end
        end else if (in_valid) begin
          load(req);
        end
      end
    end
  end

  task automatic wait_idle(input bit rnd_ready, output int n);
    n = 0;
    while (!in_ready && n < 400) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle_bound", in_ready, 1);
  endtask

  task automatic send(input logic [N-1:0] v);
    int n;
    wait_idle(1'b0, n);
    in_valid = 1'b1;
    req      = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    req      = N'($urandom);
  endtask

  initial begin
    int n;
    int exp1[4];
    int exp5[3];
    logic [N-1:0] v;
`ifdef SERIAL_PRIO_ENC_LSB_FIRST_EN
    exp1 = '{0, 5, 10, 15};
    exp5 = '{0, 1, 4};
`else
    exp1 = '{15, 10, 5, 0};
    exp5 = '{4, 1, 0};
`endif
    rst = 1'b1; in_valid = 1'b0; req = '0; out_ready = 1'b1;
    v5_in_valid = 1'b0; v5_req = '0; v5_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Four-bit pattern, full throughput
    obs_q.delete();
    send(16'h8421);
    check("t1_busy_after_capture", in_ready, 0);
    check("t1_first_idx", out_idx, exp1[0]);
    wait_idle(1'b0, n);
    check("t1_cycles", n, 4);
    check("t1_beats", obs_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_beat_idx", obs_q[i], exp1[i]);

    // Zero vector
    obs_q.delete();
    send(16'h0000);
    check("t2_valid", out_valid, 1);
    check("t2_idx",   out_idx,   0);
    check("t2_any",   out_any,   0);
    check("t2_last",  out_last,  1);
    wait_idle(1'b0, n);
    check("t2_beats", obs_q.size(), 1);

    // Backpressure hold
    obs_q.delete();
    out_ready = 1'b0;
    send(16'h0100);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_idx",   out_idx,   8);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle(1'b0, n);
    check("t3_beats", obs_q.size(), 1);
    check("t3_idx",   obs_q[0],     8);

    // Reset after the second beat
    obs_q.delete();
    send(16'h00F0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t4_rst_valid", out_valid, 0);
    check("t4_rst_ready", in_ready,  1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_beats", obs_q.size(), 2);

    // One-hot sweep
    for (int i = 0; i < N; i++) begin
      obs_q.delete();
      v = '0;
      v[i] = 1'b1;
      send(v);
      wait_idle(1'b0, n);
      check("t6_onehot_beats", obs_q.size(), 1);
      check("t6_onehot_idx",   obs_q[0],     i);
    end

    // Randomized soak with random backpressure
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 3))
        0: v = N'($urandom);
        1: v = N'(1) << $urandom_range(0, N - 1);
        2: v = '0;
        default: v = N'($urandom & $urandom & $urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(v);
      wait_idle(1'b1, n);
    end
    out_ready = 1'b1;

    // N=5 instance
    v5_req = 5'b10011;
    v5_in_valid = 1'b1;
    @(posedge clk); #1;
    v5_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("n5_valid", v5_out_valid, 1);
      check("n5_idx",   v5_out_idx,   exp5[i]);
      check("n5_any",   v5_out_any,   1);
      check("n5_last",  v5_out_last,  i == 2);
      @(posedge clk); #1;
    end
    check("n5_idle", v5_in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
